// File: rtl/virtual_uart_host_bridge.sv
// Host-side AXI-lite master for the virtual UART: drains TX bytes on interrupt into a
// local FIFO and injects RX bytes once the UART reports its RX register free.
module virtual_uart_host_bridge #(
    parameter int unsigned                 LOCAL_DATA_WIDTH = 32,
    parameter int unsigned                 LOCAL_ADDR_WIDTH = 32,
    parameter int unsigned                 LOCAL_ID_WIDTH   = 32,
    parameter logic [LOCAL_ADDR_WIDTH-1:0] UART_BASE_ADDR   = '0,
    parameter int unsigned                 TX_FIFO_DEPTH    = 4
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic                          int_xdma_i,
    output logic [LOCAL_ID_WIDTH-1:0]     m_axilite_awid_o,
    output logic [LOCAL_ADDR_WIDTH-1:0]   m_axilite_awaddr_o,
    output logic                          m_axilite_awvalid_o,
    input  logic                          m_axilite_awready_i,
    output logic [LOCAL_DATA_WIDTH-1:0]   m_axilite_wdata_o,
    output logic [LOCAL_DATA_WIDTH/8-1:0] m_axilite_wstrb_o,
    output logic                          m_axilite_wvalid_o,
    input  logic                          m_axilite_wready_i,
    input  logic [LOCAL_ID_WIDTH-1:0]     m_axilite_bid_i,
    input  logic [1:0]                    m_axilite_bresp_i,
    input  logic                          m_axilite_bvalid_i,
    output logic                          m_axilite_bready_o,
    output logic [LOCAL_ID_WIDTH-1:0]     m_axilite_arid_o,
    output logic [LOCAL_ADDR_WIDTH-1:0]   m_axilite_araddr_o,
    output logic                          m_axilite_arvalid_o,
    input  logic                          m_axilite_arready_i,
    input  logic [LOCAL_ID_WIDTH-1:0]     m_axilite_rid_i,
    input  logic [LOCAL_DATA_WIDTH-1:0]   m_axilite_rdata_i,
    input  logic [1:0]                    m_axilite_rresp_i,
    input  logic                          m_axilite_rvalid_i,
    output logic                          m_axilite_rready_o,
    output logic [7:0]                    tx_data_o,
    output logic                          tx_valid_o,
    input  logic                          tx_ready_i,
    input  logic [7:0]                    rx_data_i,
    input  logic                          rx_valid_i,
    output logic                          rx_ready_o,
    output logic                          err_o
);

    localparam int unsigned PTR_W = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    localparam logic [LOCAL_ADDR_WIDTH-1:0] ADDR_RX     = UART_BASE_ADDR;
    localparam logic [LOCAL_ADDR_WIDTH-1:0] ADDR_TX     = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(4);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] ADDR_STATUS = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(8);
    localparam logic [LOCAL_ADDR_WIDTH-1:0] ADDR_ACK    = UART_BASE_ADDR + LOCAL_ADDR_WIDTH'(16);

    typedef enum logic [3:0] {
        IDLE, TX_AR, TX_R, ACK_W, ACK_B, ST_AR, ST_R, RX_W, RX_B
    } state_e;

    state_e           state_q;
    logic [7:0]       rx_byte_q;
    logic [7:0]       mem_q [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             aw_done;
    logic             w_done;
    logic             unused_inputs;

    assign m_axilite_awid_o = '0;
    assign m_axilite_arid_o = '0;
    assign unused_inputs = ^{m_axilite_bid_i, m_axilite_rid_i,
                             m_axilite_rdata_i[LOCAL_DATA_WIDTH-1:8]};

    assign fifo_full  = (count_q == CNT_W'(TX_FIFO_DEPTH));
    assign tx_valid_o = (count_q != '0);
    assign tx_data_o  = mem_q[rptr_q];

    always_comb begin
        push    = (state_q == TX_R) && m_axilite_rvalid_i && (m_axilite_rresp_i == RESP_OKAY);
        pop     = tx_valid_o && tx_ready_i;
        aw_done = !m_axilite_awvalid_o || m_axilite_awready_i;
        w_done  = !m_axilite_wvalid_o  || m_axilite_wready_i;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < TX_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q] <= m_axilite_rdata_i[7:0];
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q             <= IDLE;
            rx_byte_q           <= '0;
            m_axilite_awaddr_o  <= '0;
            m_axilite_awvalid_o <= 1'b0;
            m_axilite_wdata_o   <= '0;
            m_axilite_wstrb_o   <= '0;
            m_axilite_wvalid_o  <= 1'b0;
            m_axilite_bready_o  <= 1'b0;
            m_axilite_araddr_o  <= '0;
            m_axilite_arvalid_o <= 1'b0;
            m_axilite_rready_o  <= 1'b0;
            rx_ready_o          <= 1'b0;
            err_o               <= 1'b0;
        end else begin
            rx_ready_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (int_xdma_i && !fifo_full) begin
                        m_axilite_araddr_o  <= ADDR_TX;
                        m_axilite_arvalid_o <= 1'b1;
                        state_q             <= TX_AR;
                    // the source drops rx_valid_i one cycle after the rx_ready_o pulse
                    end else if (rx_valid_i && !rx_ready_o) begin
                        rx_byte_q           <= rx_data_i;
                        m_axilite_araddr_o  <= ADDR_STATUS;
                        m_axilite_arvalid_o <= 1'b1;
                        state_q             <= ST_AR;
                    end
                end
                TX_AR: begin
                    if (m_axilite_arready_i) begin
                        m_axilite_arvalid_o <= 1'b0;
                        m_axilite_rready_o  <= 1'b1;
                        state_q             <= TX_R;
                    end
                end
                ST_AR: begin
                    if (m_axilite_arready_i) begin
                        m_axilite_arvalid_o <= 1'b0;
                        m_axilite_rready_o  <= 1'b1;
                        state_q             <= ST_R;
                    end
                end
                TX_R: begin
                    if (m_axilite_rvalid_i) begin
                        m_axilite_rready_o  <= 1'b0;
                        if (m_axilite_rresp_i != RESP_OKAY) begin
                            err_o <= 1'b1;
                        end
                        m_axilite_awaddr_o  <= ADDR_ACK;
                        m_axilite_wdata_o   <= LOCAL_DATA_WIDTH'(1);
                        m_axilite_wstrb_o   <= '1;
                        m_axilite_awvalid_o <= 1'b1;
                        m_axilite_wvalid_o  <= 1'b1;
                        state_q             <= ACK_W;
                    end
                end
                ST_R: begin
                    if (m_axilite_rvalid_i) begin
                        m_axilite_rready_o <= 1'b0;
                        if (m_axilite_rresp_i != RESP_OKAY) begin
                            err_o   <= 1'b1;
                            state_q <= IDLE;
                        end else if (!m_axilite_rdata_i[0]) begin
                            m_axilite_awaddr_o  <= ADDR_RX;
                            m_axilite_wdata_o   <= LOCAL_DATA_WIDTH'(rx_byte_q);
                            m_axilite_wstrb_o   <= '1;
                            m_axilite_awvalid_o <= 1'b1;
                            m_axilite_wvalid_o  <= 1'b1;
                            state_q             <= RX_W;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                ACK_W, RX_W: begin
                    if (m_axilite_awready_i) begin
                        m_axilite_awvalid_o <= 1'b0;
                    end
                    if (m_axilite_wready_i) begin
                        m_axilite_wvalid_o <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axilite_bready_o <= 1'b1;
                        if (state_q == ACK_W) begin
                            state_q <= ACK_B;
                        end else begin
                            state_q <= RX_B;
                        end
                    end
                end
                ACK_B, RX_B: begin
                    if (m_axilite_bvalid_i) begin
                        m_axilite_bready_o <= 1'b0;
                        if (m_axilite_bresp_i != RESP_OKAY) begin
                            err_o <= 1'b1;
                        end
                        if (state_q == RX_B) begin
                            rx_ready_o <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_virtual_uart_host_bridge.sv
// Scoreboard bench: a behavioural AXI-lite slave plays the virtual UART, a monitor
// compares every bus handshake, TX byte and RX acknowledge against expected queues.
module tb_virtual_uart_host_bridge;

    localparam logic [7:0] K_AR = 8'd1;
    localparam logic [7:0] K_AW = 8'd2;
    localparam logic [7:0] K_W  = 8'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_xdma;
    logic [31:0] awid, arid;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] rdata;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, err;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          exp_rx = 0;

    logic [7:0]  txq[$];
    logic [31:0] stq[$];
    int          ar_stall = 0;
    int          aw_stall = 0;
    bit          rd_err = 0;

    always #5 clk = ~clk;

    virtual_uart_host_bridge #(
        .LOCAL_DATA_WIDTH(32),
        .LOCAL_ADDR_WIDTH(32),
        .LOCAL_ID_WIDTH(32),
        .UART_BASE_ADDR(32'h0),
        .TX_FIFO_DEPTH(4)
    ) dut (
        .clock_i(clk), .reset_ni(rst_n), .int_xdma_i(int_xdma),
        .m_axilite_awid_o(awid), .m_axilite_awaddr_o(awaddr),
        .m_axilite_awvalid_o(awvalid), .m_axilite_awready_i(awready),
        .m_axilite_wdata_o(wdata), .m_axilite_wstrb_o(wstrb),
        .m_axilite_wvalid_o(wvalid), .m_axilite_wready_i(wready),
        .m_axilite_bid_i(32'h0), .m_axilite_bresp_i(bresp),
        .m_axilite_bvalid_i(bvalid), .m_axilite_bready_o(bready),
        .m_axilite_arid_o(arid), .m_axilite_araddr_o(araddr),
        .m_axilite_arvalid_o(arvalid), .m_axilite_arready_i(arready),
        .m_axilite_rid_i(32'h0), .m_axilite_rdata_i(rdata),
        .m_axilite_rresp_i(rresp), .m_axilite_rvalid_i(rvalid),
        .m_axilite_rready_o(rready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .err_o(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got unexpected event %0h want none", name, act);
    endtask

    task automatic bus_obs(input logic [7:0] k, input logic [31:0] v);
        logic [39:0] e;
        if (exp_bus.size() == 0) begin
            unexpected("bus", {k, v});
        end else begin
            e = exp_bus.pop_front();
            chk("bus", {k, v}, e);
        end
    endtask

    // AXI-lite slave model of the virtual UART; decides readies/valids on the negedge
    // and reacts one cycle after each handshake it predicted.
    initial begin : slave
        bit ar_f, r_f, aw_f, w_f, b_f, got_aw, got_w;
        logic [31:0] ar_l, aw_l;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0; got_aw = 0; got_w = 0;
        ar_l = '0; aw_l = '0;
        int_xdma = 0; arready = 0; awready = 0; wready = 0;
        rvalid = 0; rdata = '0; rresp = '0; bvalid = 0; bresp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0; got_aw = 0; got_w = 0;
                ar_stall = 0; aw_stall = 0;
                int_xdma = (txq.size() != 0);
            end else begin
                if (r_f) rvalid = 0;
                if (b_f) bvalid = 0;
                if (ar_f) begin
                    rvalid = 1;
                    rresp  = rd_err ? 2'b10 : 2'b00;
                    rd_err = 0;
                    if (ar_l == 32'h4) begin
                        rdata = (txq.size() != 0) ? {24'h0, txq[0]} : 32'h0;
                    end else if (ar_l == 32'h8) begin
                        if (stq.size() != 0) rdata = stq.pop_front();
                        else rdata = 32'h0;
                    end else begin
                        rdata = 32'hDEADBEEF;
                    end
                end
                if (aw_f) got_aw = 1;
                if (w_f) got_w = 1;
                if (got_aw && got_w) begin
                    got_aw = 0; got_w = 0;
                    bvalid = 1; bresp = 2'b00;
                    if (aw_l == 32'h10 && txq.size() != 0) void'(txq.pop_front());
                end
                int_xdma = (txq.size() != 0);
                arready = arvalid && (ar_stall == 0);
                if (arvalid && ar_stall != 0) ar_stall--;
                awready = awvalid && (aw_stall == 0);
                if (awvalid && aw_stall != 0) aw_stall--;
                wready = wvalid;
                ar_f = arvalid && arready;
                if (ar_f) ar_l = araddr;
                r_f  = rvalid && rready;
                aw_f = awvalid && awready;
                if (aw_f) aw_l = awaddr;
                w_f  = wvalid && wready;
                b_f  = bvalid && bready;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (arvalid && arready) bus_obs(K_AR, araddr);
                if (awvalid && awready) bus_obs(K_AW, awaddr);
                if (wvalid && wready) begin
                    bus_obs(K_W, wdata);
                    chk("wstrb", 64'(wstrb), 64'hF);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) unexpected("tx_byte", 64'(tx_data));
                    else chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
                end
                if (rx_ready) begin
                    if (exp_rx == 0) unexpected("rx_ready", 64'd1);
                    else begin
                        exp_rx--;
                        total++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_ar(input logic [31:0] a);
        exp_bus.push_back({K_AR, a});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back({K_AW, a});
        exp_bus.push_back({K_W, d});
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0 || exp_rx != 0) && n < max) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_in_time", 64'(n < max), 64'd1);
        repeat (4) step();
    endtask

    task automatic rx_send(input logic [7:0] d, input int max);
        int n = 0;
        bit got = 0;
        rx_valid = 1;
        rx_data  = d;
        while (!got && n < max) begin
            @(negedge clk);
            #2;
            if (rx_ready) got = 1;
            n++;
        end
        chk("rx_handshake", 64'(got), 64'd1);
        step();
        rx_valid = 0;
    endtask

    initial begin : stim
        int n;
        tx_ready = 0; rx_valid = 0; rx_data = '0;
        repeat (3) step();
        #1;
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_awvalid", 64'(awvalid), 0);
        chk("rst_wvalid",  64'(wvalid), 0);
        chk("rst_rready",  64'(rready), 0);
        chk("rst_bready",  64'(bready), 0);
        chk("rst_txvalid", 64'(tx_valid), 0);
        chk("rst_rxready", 64'(rx_ready), 0);
        chk("rst_err",     64'(err), 0);
        chk("rst_addr_data", {awaddr, wdata}, 64'h0);
        chk("rst_wstrb_ids", {wstrb, araddr[27:0], awid[15:0], arid[15:0]}, 64'h0);
        step();
        rst_n = 1;
        repeat (2) step();

        // single TX byte
        tx_ready = 1;
        exp_ar(32'h4); exp_wr(32'h10, 32'h1); exp_tx.push_back(8'h41);
        txq.push_back(8'h41);
        drain(100);
        chk("t1_int_low", 64'(int_xdma), 0);
        chk("t1_fifo_empty", 64'(tx_valid), 0);

        // FIFO fills to 4, fifth byte waits for space
        tx_ready = 0;
        for (int i = 0; i < 5; i++) txq.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) begin exp_ar(32'h4); exp_wr(32'h10, 32'h1); end
        n = 0;
        while (exp_bus.size() != 0 && n < 200) begin step(); n++; end
        chk("t2_fill_in_time", 64'(n < 200), 64'd1);
        repeat (10) step();
        chk("t2_full_head", {tx_valid, tx_data}, {1'b1, 8'h10});
        chk("t2_pending", 64'(txq.size()), 64'd1);
        exp_ar(32'h4); exp_wr(32'h10, 32'h1);
        for (int i = 0; i < 5; i++) exp_tx.push_back(8'h10 + 8'(i));
        tx_ready = 1;
        drain(200);

        // RX write with STATUS free
        exp_ar(32'h8); exp_wr(32'h0, 32'h5A); exp_rx++;
        rx_send(8'h5A, 100);
        drain(50);

        // STATUS busy for three polls
        stq.push_back(32'h1); stq.push_back(32'h1); stq.push_back(32'h1);
        for (int i = 0; i < 4; i++) exp_ar(32'h8);
        exp_wr(32'h0, 32'hC3); exp_rx++;
        rx_send(8'hC3, 200);
        drain(50);

        // TX and RX raised together: TX completes first
        exp_ar(32'h4); exp_wr(32'h10, 32'h1); exp_tx.push_back(8'h77);
        exp_ar(32'h8); exp_wr(32'h0, 32'h99); exp_rx++;
        txq.push_back(8'h77);
        rx_send(8'h99, 200);
        drain(50);

        // error response on TX read
        rd_err = 1;
        exp_ar(32'h4); exp_wr(32'h10, 32'h1);
        txq.push_back(8'hEE);
        drain(100);
        chk("t6_err_set", 64'(err), 1);
        chk("t6_no_push", 64'(tx_valid), 0);
        exp_ar(32'h4); exp_wr(32'h10, 32'h1); exp_tx.push_back(8'h42);
        txq.push_back(8'h42);
        drain(100);
        chk("t6_err_sticky", 64'(err), 1);

        // arready stalled for five cycles
        ar_stall = 5;
        exp_ar(32'h4); exp_wr(32'h10, 32'h1); exp_tx.push_back(8'h33);
        txq.push_back(8'h33);
        n = 0;
        while (!arvalid && n < 50) begin @(negedge clk); #2; n++; end
        chk("t7_ar_seen", 64'(arvalid), 1);
        for (int i = 0; i < 5; i++) begin
            chk("t7_ar_stable", {arvalid, araddr}, {1'b1, 32'h4});
            @(negedge clk);
            #2;
        end
        drain(100);

        // reset while waiting for awready
        tx_ready = 0;
        aw_stall = 50;
        exp_ar(32'h4); exp_bus.push_back({K_W, 32'h1});
        txq.push_back(8'h55);
        n = 0;
        while (!awvalid && n < 50) begin @(negedge clk); #2; n++; end
        chk("t8_aw_seen", 64'(awvalid), 1);
        repeat (2) step();
        rst_n = 0;
        txq.delete();
        #1;
        chk("t8_valids_low", {arvalid, awvalid, wvalid, bready, rready}, 0);
        chk("t8_fifo_empty", 64'(tx_valid), 0);
        chk("t8_err_clear", 64'(err), 0);
        repeat (3) step();
        rst_n = 1;
        repeat (6) step();
        chk("t8_idle", {arvalid, awvalid, wvalid}, 0);
        chk("t8_bus_done", 64'(exp_bus.size()), 0);
        tx_ready = 1;
        exp_ar(32'h4); exp_wr(32'h10, 32'h1); exp_tx.push_back(8'h66);
        txq.push_back(8'h66);
        drain(100);

        chk("end_bus_empty", 64'(exp_bus.size()), 0);
        chk("end_tx_empty", 64'(exp_tx.size()), 0);
        chk("end_rx_empty", 64'(exp_rx), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
